// File: rtl/div_issue_pkg.sv
// div_issue_pkg -- shared definitions for the divider issue block.
//   div_state_e          : issue FSM state encodings
//   DIV_START / DIV_STOP : levels of div_start_o toward the divider
//   DIV_TIMEOUT_DEFAULT  : default WAIT-state watchdog limit (cycles)
//   ABORT_CYCLES         : length of the annul window after a cancel
//   stall_needed()       : stall rule shared by the issue block
package div_issue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_DONE  = 2'b10,
    ST_ABORT = 2'b11
  } div_state_e;

  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

  localparam int unsigned DIV_TIMEOUT_DEFAULT = 48;
  localparam int unsigned ABORT_CYCLES        = 2;

  // The pipeline must hold while a divide is outstanding, and also in the
  // cycle a new DIV/DIVU is presented (it only issues at the next edge).
  function automatic logic stall_needed(input div_state_e state,
                                        input logic       req,
                                        input logic       flush);
    case (state)
      ST_WAIT:          return 1'b1;
      ST_IDLE, ST_DONE: return req && !flush;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/div_watchdog.sv
// div_watchdog -- WAIT-state cycle counter for the divider issue block.
//   clk, rst : clock, synchronous active-high reset
//   clear    : restart the count (asserted on WAIT entry)
//   enable   : count this cycle (asserted while in WAIT)
//   expired  : this enabled cycle is the LIMIT-th one since clear
module div_watchdog
  import div_issue_pkg::*;
#(
  parameter int unsigned LIMIT = DIV_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  // count holds the number of enabled cycles already completed, so it
  // equals LIMIT-1 during the LIMIT-th one; it parks there once expired.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/div_issue.sv
// div_issue -- issues DIV/DIVU from EX to a multi-cycle divider, stalls the
// pipeline until the result returns, and writes it to HI/LO.
//   clk, rst                        : clock, synchronous active-high reset
//   div_req_i, div_signed_i         : EX holds DIV (signed=1) or DIVU
//   op1_i, op2_i                    : dividend, divisor
//   flush_i                         : cancels a pending divide
//   div_result_i, div_ready_i       : divider {remainder, quotient} + valid
//   div_start_o, div_annul_o,
//   div_signed_o                    : divider controls (registered)
//   div_opdata1_o, div_opdata2_o    : latched operands (registered)
//   stallreq_o                      : pipeline stall (combinational)
//   whilo_o, hi_o, lo_o             : one-cycle HI/LO write + data
//   div_err_o                       : one-cycle watchdog abort pulse
// Build option: define DIV_TIMEOUT_EN to enable the WAIT watchdog
// (limit = DIV_TIMEOUT cycles); otherwise div_err_o is tied low.
module div_issue
  import div_issue_pkg::*;
#(
  parameter int unsigned DIV_TIMEOUT = DIV_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_req_i,
  input  logic        div_signed_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic        flush_i,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_opdata1_o,
  output logic [31:0] div_opdata2_o,
  output logic        stallreq_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_err_o
);

  div_state_e state;
  logic       abort_cnt;
  logic       issue;
  logic       timeout;

  assign issue = div_req_i && !flush_i;

`ifdef DIV_TIMEOUT_EN
  logic wd_clear;
  logic wd_enable;

  assign wd_clear  = (state == ST_IDLE) && issue;
  assign wd_enable = (state == ST_WAIT);

  div_watchdog #(
    .LIMIT(DIV_TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(timeout)
  );

  // Expiry is detected in the DIV_TIMEOUT-th WAIT cycle; the registered
  // pulse shows alongside the first ABORT cycle. A result arriving in that
  // same cycle, or a flush, takes precedence over the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_err_o <= 1'b0;
    end else begin
      div_err_o <= (state == ST_WAIT) && timeout && !flush_i && !div_ready_i;
    end
  end
`else
  logic unused_cfg;

  // DIV_TIMEOUT only matters for the watchdog build.
  assign unused_cfg = ^DIV_TIMEOUT;
  assign timeout    = 1'b0;
  assign div_err_o  = 1'b0;
`endif

  always_comb begin
    stallreq_o = stall_needed(state, div_req_i, flush_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      abort_cnt     <= 1'b0;
      div_start_o   <= DIV_STOP;
      div_annul_o   <= 1'b0;
      div_signed_o  <= 1'b0;
      div_opdata1_o <= '0;
      div_opdata2_o <= '0;
      whilo_o       <= 1'b0;
      hi_o          <= '0;
      lo_o          <= '0;
    end else begin
      whilo_o <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (issue) begin
            div_opdata1_o <= op1_i;
            div_opdata2_o <= op2_i;
            div_signed_o  <= div_signed_i;
            div_start_o   <= DIV_START;
            div_annul_o   <= 1'b0;
            state         <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          // Flush beats a simultaneous result; a result beats the timeout.
          if (flush_i || (timeout && !div_ready_i)) begin
            div_start_o <= DIV_STOP;
            div_annul_o <= 1'b1;
            abort_cnt   <= 1'b0;
            state       <= ST_ABORT;
          end else if (div_ready_i) begin
            hi_o        <= div_result_i[63:32];
            lo_o        <= div_result_i[31:0];
            whilo_o     <= 1'b1;
            div_start_o <= DIV_STOP;
            state       <= ST_DONE;
          end
        end

        // One stopped cycle lets the divider return to free before a new
        // request can issue from IDLE.
        ST_DONE: begin
          div_start_o <= DIV_STOP;
          state       <= ST_IDLE;
        end

        ST_ABORT: begin
          div_start_o <= DIV_STOP;
          if (abort_cnt == 1'(ABORT_CYCLES - 1)) begin
            div_annul_o <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            abort_cnt <= abort_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue.sv
module tb_div_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        div_req_i = 1'b0;
  logic        div_signed_i = 1'b0;
  logic [31:0] op1_i = '0;
  logic [31:0] op2_i = '0;
  logic        flush_i = 1'b0;
  logic [63:0] div_result_i = '0;
  logic        div_ready_i = 1'b0;
  logic        div_start_o;
  logic        div_annul_o;
  logic        div_signed_o;
  logic [31:0] div_opdata1_o;
  logic [31:0] div_opdata2_o;
  logic        stallreq_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        div_err_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Architectural HI/LO as the reference model sees them.
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  div_issue #(
    .DIV_TIMEOUT(48)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .div_req_i    (div_req_i),
    .div_signed_i (div_signed_i),
    .op1_i        (op1_i),
    .op2_i        (op2_i),
    .flush_i      (flush_i),
    .div_result_i (div_result_i),
    .div_ready_i  (div_ready_i),
    .div_start_o  (div_start_o),
    .div_annul_o  (div_annul_o),
    .div_signed_o (div_signed_o),
    .div_opdata1_o(div_opdata1_o),
    .div_opdata2_o(div_opdata2_o),
    .stallreq_o   (stallreq_o),
    .whilo_o      (whilo_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o),
    .div_err_o    (div_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input logic start, input logic annul,
                           input logic whilo, input logic stall, input logic err);
    check({tag, "_start"}, 64'(div_start_o), 64'(start));
    check({tag, "_annul"}, 64'(div_annul_o), 64'(annul));
    check({tag, "_whilo"}, 64'(whilo_o), 64'(whilo));
    check({tag, "_stall"}, 64'(stallreq_o), 64'(stall));
    check({tag, "_err"}, 64'(div_err_o), 64'(err));
  endtask

  task automatic check_hilo(input string tag);
    check({tag, "_hi"}, 64'(hi_o), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo_o), 64'(exp_lo));
  endtask

  // Reference divider: {remainder, quotient}, truncating toward zero,
  // zero result for a zero divisor.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return '0;
    if (sgn) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // One bench cycle: drive at the falling edge, look 1 ns later.
  task automatic drive(input logic req, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input logic fl, input logic rdy,
                       input logic [63:0] res);
    @(negedge clk);
    rst          = 1'b0;
    div_req_i    = req;
    div_signed_i = sgn;
    op1_i        = a;
    op2_i        = b;
    flush_i      = fl;
    div_ready_i  = rdy;
    div_result_i = res;
    #1;
  endtask

  task automatic rst_cycle();
    @(negedge clk);
    rst         = 1'b1;
    div_req_i   = 1'b0;
    flush_i     = 1'b0;
    div_ready_i = 1'b0;
    #1;
  endtask

  task automatic drive_junk(input logic req, input logic fl, input logic rdy);
    drive(req, 1'($urandom), $urandom, $urandom, fl, rdy, {$urandom, $urandom});
  endtask

  // One DIV/DIVU transaction. lat: WAIT cycle on which the divider answers.
  // flush_at: WAIT cycle carrying flush (0 = none). chain: EX presents the
  // next divide already in the cycle the result is written.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                         input int unsigned lat, input int unsigned flush_at,
                         input logic chain);
    logic [63:0]  res;
    logic         flushed;
    int unsigned  last;
    res     = ref_div(a, b, sgn);
    flushed = (flush_at != 0) && (flush_at <= lat);
    last    = flushed ? flush_at : lat;

    drive(1'b1, sgn, a, b, 1'b0, 1'b0, '0);
    check_ctl("req", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int unsigned j = 1; j <= last; j++) begin
      if (j == lat)
        drive(1'b1, 1'($urandom), $urandom, $urandom, 1'(j == flush_at), 1'b1, res);
      else
        drive_junk(1'b1, 1'(j == flush_at), 1'b0);
      check_ctl("wait", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      check("wait_op1", 64'(div_opdata1_o), 64'(a));
      check("wait_op2", 64'(div_opdata2_o), 64'(b));
      check("wait_sgn", 64'(div_signed_o), 64'(sgn));
    end

    if (flushed) begin
      for (int unsigned k = 0; k < 2; k++) begin
        drive_junk(1'($urandom), 1'b0, 1'($urandom));
        check_ctl("abort", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_hilo("abort");
      end
      drive_junk(1'b0, 1'b0, 1'b0);
      check_ctl("post_abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end else begin
      exp_hi = res[63:32];
      exp_lo = res[31:0];
      drive_junk(chain, 1'b0, 1'b0);
      check_ctl("done", 1'b0, 1'b0, 1'b1, chain, 1'b0);
      check_hilo("done");
      if (!chain) begin
        drive_junk(1'b0, 1'b0, 1'b0);
        check_ctl("after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_hilo("after");
      end
    end
  endtask

  task automatic idle_cycle();
    logic req;
    logic fl;
    req = 1'($urandom);
    fl  = req ? 1'b1 : 1'($urandom);
    drive_junk(req, fl, 1'b0);
    check_ctl("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_hilo("idle");
  endtask

`ifdef DIV_TIMEOUT_EN
  task automatic run_timeout();
    drive(1'b1, 1'b0, 32'd77, 32'd3, 1'b0, 1'b0, '0);
    check_ctl("to_req", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int unsigned j = 1; j <= 48; j++) begin
      drive_junk(1'b1, 1'b0, 1'b0);
      check_ctl("to_wait", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    for (int unsigned k = 0; k < 2; k++) begin
      drive_junk(1'b0, 1'b0, 1'b0);
      check_ctl("to_abort", 1'b0, 1'b1, 1'b0, 1'b0, 1'(k == 0));
    end
    drive_junk(1'b0, 1'b0, 1'b0);
    check_ctl("to_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL time_limit got=running exp=finished");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic        sgn;
    int unsigned lat;
    int unsigned fat;
    logic        chain;

    rst_cycle();
    rst_cycle();
    check_ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_sgn", 64'(div_signed_o), 64'd0);
    check("rst_op1", 64'(div_opdata1_o), 64'd0);
    check("rst_op2", 64'(div_opdata2_o), 64'd0);
    check_hilo("rst");

    // Issue on the very first edge out of reset.
    run_div(32'd100, 32'd7, 1'b0, 5, 0, 1'b0);
    check("divu_100_7_hi", 64'(hi_o), 64'd2);
    check("divu_100_7_lo", 64'(lo_o), 64'd14);

    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 3, 0, 1'b0);
    check("div_m7_2_hi", 64'(hi_o), 64'hFFFF_FFFF);
    check("div_m7_2_lo", 64'(lo_o), 64'hFFFF_FFFD);

    run_div(32'd5, 32'd0, 1'b0, 2, 0, 1'b0);
    check("divu_5_0_hi", 64'(hi_o), 64'd0);
    check("divu_5_0_lo", 64'(lo_o), 64'd0);

    run_div(32'd100, 32'd7, 1'b0, 20, 10, 1'b0);
    run_div(32'd9, 32'd3, 1'b0, 4, 0, 1'b0);
    check("divu_9_3_hi", 64'(hi_o), 64'd0);
    check("divu_9_3_lo", 64'(lo_o), 64'd3);

    // Flush coinciding with the result: flush must win.
    run_div(32'd40, 32'd6, 1'b0, 3, 3, 1'b0);

    run_div(32'd8, 32'd2, 1'b0, 4, 0, 1'b1);
    check("divu_8_2_lo", 64'(lo_o), 64'd4);
    run_div(32'd9, 32'd4, 1'b0, 2, 0, 1'b0);
    check("divu_9_4_hi", 64'(hi_o), 64'd1);
    check("divu_9_4_lo", 64'(lo_o), 64'd2);

    // Reset in the middle of WAIT.
    drive(1'b1, 1'b0, 32'd50, 32'd5, 1'b0, 1'b0, '0);
    for (int unsigned j = 0; j < 3; j++) drive_junk(1'b1, 1'b0, 1'b0);
    check("mid_start", 64'(div_start_o), 64'd1);
    rst_cycle();
    rst_cycle();
    exp_hi = '0;
    exp_lo = '0;
    check_ctl("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mid_rst_op1", 64'(div_opdata1_o), 64'd0);
    check_hilo("mid_rst");
    run_div(32'd21, 32'd4, 1'b0, 1, 0, 1'b0);

`ifdef DIV_TIMEOUT_EN
    run_timeout();
`else
    // No watchdog: WAIT holds (stall high) until the flush on cycle 60.
    run_div(32'd100, 32'd7, 1'b0, 200, 60, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      a   = $urandom;
      sgn = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      lat   = $urandom_range(1, 12);
      fat   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, lat) : 0;
      chain = (fat == 0) && ($urandom_range(0, 2) == 0);
      run_div(a, b, sgn, lat, fat, chain);
      if (!chain) begin
        for (int unsigned n = $urandom_range(0, 3); n > 0; n--) idle_cycle();
      end
    end
    idle_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
